// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 interrupt controller: C0 register map,
// Status bit positions and the Cause valid-bit position.
package cp0_pkg;

    localparam logic [4:0] C0_EPC    = 5'd0;
    localparam logic [4:0] C0_CAUSE  = 5'd1;
    localparam logic [4:0] C0_STATUS = 5'd2;
    localparam logic [4:0] C0_MASK   = 5'd3;
    localparam logic [4:0] C0_PEND   = 5'd4;
    localparam logic [4:0] C0_MODE   = 5'd5;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;

    function automatic int cause_vld_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/cp0_irq_pending.sv
// Pending-bit tracking (edge/level per source), masking and lowest-index-wins
// priority; pending updates one edge after irq sampling, winner is combinational.
module cp0_irq_pending #(
    parameter int N_IRQ = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic [N_IRQ-1:0] i_mode,
    input  logic [N_IRQ-1:0] i_mask,
    input  logic             i_w1c_vld,
    input  logic [N_IRQ-1:0] i_w1c_dat,
    input  logic             i_take,
    output logic [N_IRQ-1:0] o_pend,
    output logic             o_any,
    output logic [IDX_W-1:0] o_win
);

    logic [N_IRQ-1:0] r_samp;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] w_elig;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_w1c;
    logic [N_IRQ-1:0] w_take_clr;
    logic [N_IRQ-1:0] w_edge_nxt;
    logic [IDX_W-1:0] w_win;

    assign w_elig = r_pend & i_mask;
    assign w_rise = i_irq & ~r_samp;
    assign w_w1c  = i_w1c_vld ? i_w1c_dat : '0;

    // Scan downwards so the lowest eligible index is the last assignment.
    always_comb begin
        w_win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) w_win = IDX_W'(i);
        end
    end

    assign w_take_clr = i_take ? (N_IRQ'(1) << w_win) : '0;
    // A fresh rising edge survives any clear landing in the same cycle.
    assign w_edge_nxt = w_rise | (r_pend & ~w_w1c & ~w_take_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp <= '0;
            r_pend <= '0;
        end else begin
            r_samp <= i_irq;
            r_pend <= (i_mode & w_edge_nxt) | (~i_mode & i_irq);
        end
    end

    assign o_pend = r_pend;
    assign o_any  = |w_elig;
    assign o_win  = w_win;

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor 0 (EPC/Cause/Status) with a vectored, fixed-priority interrupt controller.
// C0 reads are registered (1 cycle); int_req/int_vector are combinational from state.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                N_IRQ      = 8,
    parameter logic [DATA_W-1:0] VEC_BASE   = DATA_W'(32'h0000_0080),
    parameter int                VEC_STRIDE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        c0_adr,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic              c0_write,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic [DATA_W-1:0] epc_in,
    input  logic              int_take,
    input  logic              eret,
    output logic              int_req,
    output logic [DATA_W-1:0] int_vector,
    output logic [DATA_W-1:0] c0_status
);

    localparam int IDX_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int CAUSE_VLD = cause_vld_bit(DATA_W);

    logic [DATA_W-1:0] r_epc;
    logic [DATA_W-1:0] r_cause;
    logic [DATA_W-1:0] r_status;
    logic [N_IRQ-1:0]  r_mask;
    logic [N_IRQ-1:0]  r_mode;
    logic [DATA_W-1:0] r_rdata;

    logic [N_IRQ-1:0]  w_pend;
    logic              w_any;
    logic [IDX_W-1:0]  w_win;
    logic              w_req;
    logic              w_take;
    logic              w_wr_epc;
    logic              w_wr_cause;
    logic              w_wr_status;
    logic              w_wr_mask;
    logic              w_wr_pend;
    logic              w_wr_mode;
    logic [DATA_W-1:0] w_status_nxt;
    logic [DATA_W-1:0] w_cause_take;
    logic [DATA_W-1:0] w_rdata;

    assign w_wr_epc    = c0_write && (c0_adr == C0_EPC);
    assign w_wr_cause  = c0_write && (c0_adr == C0_CAUSE);
    assign w_wr_status = c0_write && (c0_adr == C0_STATUS);
    assign w_wr_mask   = c0_write && (c0_adr == C0_MASK);
    assign w_wr_pend   = c0_write && (c0_adr == C0_PEND);
    assign w_wr_mode   = c0_write && (c0_adr == C0_MODE);

    assign w_req  = w_any & r_status[ST_IE] & ~r_status[ST_EXL];
    // eret wins over a same-cycle take; int_req is low while EXL=1 anyway.
    assign w_take = int_take & w_req & ~eret;

    cp0_irq_pending #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_pending (
        .clk       (clk),
        .rst       (rst),
        .i_irq     (irq_in),
        .i_mode    (r_mode),
        .i_mask    (r_mask),
        .i_w1c_vld (w_wr_pend),
        .i_w1c_dat (c0_wdata[N_IRQ-1:0]),
        .i_take    (w_take),
        .o_pend    (w_pend),
        .o_any     (w_any),
        .o_win     (w_win)
    );

    always_comb begin
        w_cause_take                = '0;
        w_cause_take[CAUSE_VLD]     = 1'b1;
        w_cause_take[IDX_W-1:0]     = w_win;
    end

    // Ordering gives: written value beats eret, then take forces EXL on top.
    always_comb begin
        w_status_nxt = r_status;
        if (eret)        w_status_nxt[ST_EXL] = 1'b0;
        if (w_wr_status) w_status_nxt         = c0_wdata;
        if (w_take)      w_status_nxt[ST_EXL] = 1'b1;
    end

    always_comb begin
        w_rdata = '0;
        case (c0_adr)
            C0_EPC:    w_rdata = r_epc;
            C0_CAUSE:  w_rdata = r_cause;
            C0_STATUS: w_rdata = r_status;
            C0_MASK:   w_rdata = DATA_W'(r_mask);
            C0_PEND:   w_rdata = DATA_W'(w_pend);
            C0_MODE:   w_rdata = DATA_W'(r_mode);
            default:   w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc    <= '0;
            r_cause  <= '0;
            r_status <= DATA_W'(1);
            r_mask   <= '0;
            r_mode   <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_take) begin
                r_epc   <= epc_in;
                r_cause <= w_cause_take;
            end else begin
                if (w_wr_epc)   r_epc   <= c0_wdata;
                if (w_wr_cause) r_cause <= c0_wdata;
            end
            r_status <= w_status_nxt;
            if (w_wr_mask) r_mask <= c0_wdata[N_IRQ-1:0];
            if (w_wr_mode) r_mode <= c0_wdata[N_IRQ-1:0];
            r_rdata  <= w_rdata;
        end
    end

    assign c0_rdata   = r_rdata;
    assign c0_status  = r_status;
    assign int_req    = w_req;
    assign int_vector = w_any ? (VEC_BASE + DATA_W'(w_win) * DATA_W'(VEC_STRIDE)) : '0;

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: register reset values, edge/level pending,
// priority and vectors, take/eret handshake, same-cycle collisions, async reset.
module tb_cp0_intc;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  c0_adr;
    logic [31:0] c0_wdata;
    logic        c0_write;
    logic [31:0] c0_rdata;
    logic [7:0]  irq_in;
    logic [31:0] epc_in;
    logic        int_take;
    logic        eret;
    logic        int_req;
    logic [31:0] int_vector;
    logic [31:0] c0_status;

    int n_chk  = 0;
    int n_fail = 0;

    cp0_intc dut (
        .clk        (clk),
        .rst        (rst),
        .c0_adr     (c0_adr),
        .c0_wdata   (c0_wdata),
        .c0_write   (c0_write),
        .c0_rdata   (c0_rdata),
        .irq_in     (irq_in),
        .epc_in     (epc_in),
        .int_take   (int_take),
        .eret       (eret),
        .int_req    (int_req),
        .int_vector (int_vector),
        .c0_status  (c0_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic c0_wr(input logic [4:0] adr, input logic [31:0] dat);
        c0_adr   = adr;
        c0_wdata = dat;
        c0_write = 1'b1;
        step();
        c0_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        c0_adr = adr;
        step();
        chk(tag, c0_rdata, exp);
    endtask

    task automatic take(input logic [31:0] pc);
        epc_in   = pc;
        int_take = 1'b1;
        step();
        int_take = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; c0_adr = '0; c0_wdata = '0; c0_write = 1'b0;
        irq_in = '0; epc_in = '0; int_take = 1'b0; eret = 1'b0;
        step(); step();
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_status_out", c0_status, 32'h1);
        rst = 1'b0;
        step();

        // Reset values through the read port
        rd_chk("rst_epc",    5'd0, 32'h0);
        rd_chk("rst_cause",  5'd1, 32'h0);
        rd_chk("rst_status", 5'd2, 32'h1);
        rd_chk("rst_mask",   5'd3, 32'h0);
        rd_chk("rst_pend",   5'd4, 32'h0);
        rd_chk("rst_mode",   5'd5, 32'h0);
        rd_chk("unmapped",   5'd7, 32'h0);
        chk("rst_vector", int_vector, 32'h0);

        // Single edge source 2
        c0_wr(5'd3, 32'h04);
        c0_wr(5'd5, 32'h04);
        c0_wr(5'd7, 32'hFFFF);
        rd_chk("unmapped_wr", 5'd7, 32'h0);
        irq_in = 8'h04; step(); irq_in = 8'h00;
        chk("e2_req", {31'b0, int_req}, 32'h1);
        chk("e2_vec", int_vector, 32'hA0);
        take(32'h400);
        chk("e2_status", c0_status, 32'h3);
        chk("e2_req_exl", {31'b0, int_req}, 32'h0);
        chk("e2_vec_none", int_vector, 32'h0);
        rd_chk("e2_epc",   5'd0, 32'h400);
        rd_chk("e2_cause", 5'd1, 32'h8000_0002);
        rd_chk("e2_pend",  5'd4, 32'h0);
        do_eret();
        chk("e2_eret_status", c0_status, 32'h1);
        rd_chk("e2_eret_epc", 5'd0, 32'h400);

        // Sources 1 and 5 together: lowest index first
        c0_wr(5'd3, 32'h22);
        c0_wr(5'd5, 32'h22);
        irq_in = 8'h22; step(); irq_in = 8'h00;
        chk("p15_req", {31'b0, int_req}, 32'h1);
        chk("p15_vec1", int_vector, 32'h90);
        take(32'h500);
        rd_chk("p15_cause1", 5'd1, 32'h8000_0001);
        rd_chk("p15_pend",   5'd4, 32'h20);
        do_eret();
        chk("p15_req5", {31'b0, int_req}, 32'h1);
        chk("p15_vec5", int_vector, 32'hD0);
        take(32'h504);
        rd_chk("p15_cause5", 5'd1, 32'h8000_0005);
        do_eret();
        chk("p15_idle", {31'b0, int_req}, 32'h0);

        // Level source 3 held high across a handler
        c0_wr(5'd3, 32'h08);
        c0_wr(5'd5, 32'h00);
        irq_in = 8'h08; step();
        chk("lv_req", {31'b0, int_req}, 32'h1);
        chk("lv_vec", int_vector, 32'hB0);
        take(32'h600);
        chk("lv_req_exl", {31'b0, int_req}, 32'h0);
        c0_wr(5'd4, 32'h08);
        rd_chk("lv_w1c_pend", 5'd4, 32'h08);
        rd_chk("lv_cause",    5'd1, 32'h8000_0003);
        do_eret();
        chk("lv_req_again", {31'b0, int_req}, 32'h1);
        irq_in = 8'h00; step();
        chk("lv_req_drop", {31'b0, int_req}, 32'h0);

        // Status cleared in the same cycle an edge arrives
        c0_wr(5'd3, 32'h01);
        c0_wr(5'd5, 32'h01);
        irq_in = 8'h01; c0_adr = 5'd2; c0_wdata = 32'h0; c0_write = 1'b1;
        step();
        irq_in = 8'h00; c0_write = 1'b0;
        chk("ie0_req", {31'b0, int_req}, 32'h0);
        chk("ie0_status", c0_status, 32'h0);
        rd_chk("ie0_pend", 5'd4, 32'h01);
        c0_wr(5'd2, 32'h1);
        chk("ie1_req", {31'b0, int_req}, 32'h1);
        chk("ie1_vec", int_vector, 32'h80);

        // Take with a Status write: written value, then EXL forced
        c0_adr = 5'd2; c0_wdata = 32'h10; c0_write = 1'b1;
        epc_in = 32'h700; int_take = 1'b1;
        step();
        c0_write = 1'b0; int_take = 1'b0;
        chk("tw_status", c0_status, 32'h12);
        rd_chk("tw_epc", 5'd0, 32'h700);
        // eret with a Status write: written value wins
        c0_adr = 5'd2; c0_wdata = 32'h3; c0_write = 1'b1; eret = 1'b1;
        step();
        c0_write = 1'b0; eret = 1'b0;
        chk("ew_status", c0_status, 32'h3);
        c0_wr(5'd2, 32'h1);
        chk("ew_req_none", {31'b0, int_req}, 32'h0);

        // Async reset while in a handler with a new pending bit
        c0_wr(5'd3, 32'h40);
        c0_wr(5'd5, 32'h40);
        irq_in = 8'h40; step(); irq_in = 8'h00;
        chk("r6_vec", int_vector, 32'hE0);
        take(32'h800);
        step();
        irq_in = 8'h40; step(); irq_in = 8'h00;
        chk("r6_status_exl", c0_status, 32'h3);
        rd_chk("r6_pend", 5'd4, 32'h40);
        c0_adr = 5'd0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req", {31'b0, int_req}, 32'h0);
        chk("ar_status", c0_status, 32'h1);
        chk("ar_vec", int_vector, 32'h0);
        chk("ar_rdata", c0_rdata, 32'h0);
        step();
        rst = 1'b0;
        step();
        rd_chk("ar_epc",   5'd0, 32'h0);
        rd_chk("ar_cause", 5'd1, 32'h0);
        rd_chk("ar_stat",  5'd2, 32'h1);
        rd_chk("ar_mask",  5'd3, 32'h0);
        rd_chk("ar_pend",  5'd4, 32'h0);
        rd_chk("ar_mode",  5'd5, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_intc.md
# cp0_intc

Parametrised successor to the single-source coprocessor 0: holds EPC, Cause and Status, and adds a vectored interrupt controller with N_IRQ sources, per-source mask, per-source edge/level mode, fixed priority and an explicit take/return handshake with the CPU. It sits beside the CPU datapath, serves MFC0/MTC0 accesses through the C0 port, and tells the control unit when and where to divert the PC.

## Interface
- DATA_W, 32: register and data width (≥16).
- N_IRQ, 8: interrupt source count (1..16).
- VEC_BASE, 32'h0000_0080: handler vector base.
- VEC_STRIDE, 16: byte distance between per-source vectors (power of two).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- c0_adr  in  5  register address.
- c0_wdata  in  DATA_W  write data.
- c0_write  in  1  write strobe.
- c0_rdata  out  DATA_W  registered read data.
- irq_in  in  N_IRQ  interrupt lines, already synchronous to clk.
- epc_in  in  DATA_W  PC to save on take.
- int_take  in  1  CPU accepts current request this cycle.
- eret  in  1  return from handler.
- int_req  out  1  interrupt request to CPU.
- int_vector  out  DATA_W  handler address for the winning source.
- c0_status  out  DATA_W  live Status register.

## Operation
- Registers: 0 EPC, 1 Cause, 2 Status, 3 Mask, 4 Pending (write-1-to-clear), 5 Mode (1 = edge, 0 = level); other addresses: writes ignored, read 0.
- Status bit 0 IE (global enable), bit 1 EXL (in handler); other bits plain storage.
- Pending: edge source sets its bit on 0→1 of irq_in versus the previous-cycle sample; level source bit equals registered irq_in each cycle and ignores W1C.
- Eligible = Pending & Mask; winner = lowest-index eligible bit.
- int_req = |eligible & IE & ~EXL.
- int_vector = VEC_BASE + winner*VEC_STRIDE; 0 when no eligible bit.
- int_take with int_req high: EPC←epc_in, EXL←1, Cause←{1'b1 at bit DATA_W-1, winner index in low bits, zeros elsewhere}, winner's pending bit cleared if edge mode. int_take with int_req low: ignored.
- eret: EXL←0; EPC and Cause unchanged.
- Simultaneous events: take beats a C0 write to EPC/Cause; a Status write in a take cycle applies c0_wdata then forces EXL=1; eret and a Status write in the same cycle: written value wins; new edge and W1C on the same bit: set wins; take and eret together (impossible while EXL=1, since int_req is then low): eret applies, take ignored.
- Arithmetic: vector sum truncated to DATA_W, no overflow flag.

## Timing
- Reset: EPC 0, Cause 0, Status 1 (IE=1, EXL=0), Mask 0, Pending 0, Mode 0, edge sample 0, c0_rdata 0, int_req 0, int_vector 0, c0_status 1.
- irq_in rise at edge n → pending set at edge n+1 → int_req high after edge n+1 (combinational from registers).
- Read latency 1: c0_rdata at edge n+1 reflects register value before any write at edge n+1.
- Write visible in c0_status/int_req after the writing edge.
- Reset asserted mid-handler: all state returns to reset values immediately, int_req drops asynchronously.

## Structure
- Package cp0_pkg: register address constants, Status bit indices (IE, EXL), Cause valid bit position.
- Sub-module cp0_irq_pending: edge sampling, pending/W1C logic, mask, priority encoder; outputs eligible flag and winner index.

## Test plan
- Reset release → Status reads 1, all others 0, int_req 0.
- Mask=8'h04, Mode=8'h04, pulse irq_in[2] → int_req next cycle, int_vector 32'hA0; take with epc_in 32'h400 → EPC 32'h400, Cause 32'h8000_0002, Status 3, pending[2] cleared.
- irq_in[1] and [5] eligible together → winner 1; after take+eret, source 5 (still pending) requested with vector 32'hD0.
- Level source 3 held high, handler runs, eret with line still high → int_req reasserts next cycle; W1C on bit 3 has no effect.
- Status write 0 in the cycle an edge arrives → no int_req; later write IE=1 → int_req high cycle after.
- Assert rst during EXL=1 with pending bits → all registers to reset values, int_req 0 while rst high.
